// File: rtl/instr_fetch_pkg.sv
// Shared encodings for the instruction-fetch stage: PC source select, FSM states and the
// special instruction words.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_JR     = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        StLoad   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } state_e;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_if.sv
// Control, debug-load and IF/ID signals of the fetch stage. The slave modport is the fetch
// stage itself; the master modport is whoever drives it (pipeline control, debug unit, bench).
interface instr_fetch_if #(
    parameter int unsigned NBITS  = 32,
    parameter int unsigned ADDR_W = 6
);
    import instr_fetch_pkg::*;

    logic              i_enable;
    logic              i_start;
    logic              i_stall;
    pc_src_e           i_pc_src;
    logic [NBITS-1:0]  i_branch_addr;
    logic [NBITS-1:0]  i_jump_addr;
    logic [NBITS-1:0]  i_jr_addr;
    logic              i_load_we;
    logic [ADDR_W-1:0] i_load_addr;
    logic [NBITS-1:0]  i_load_data;
    logic [NBITS-1:0]  o_pc;
    logic [NBITS-1:0]  o_pc_next;
    logic [NBITS-1:0]  o_instruction;
    logic              o_halt;
    state_e            o_state;

    modport slave (
        input  i_enable, i_start, i_stall, i_pc_src, i_branch_addr, i_jump_addr, i_jr_addr,
        input  i_load_we, i_load_addr, i_load_data,
        output o_pc, o_pc_next, o_instruction, o_halt, o_state
    );

    modport master (
        output i_enable, i_start, i_stall, i_pc_src, i_branch_addr, i_jump_addr, i_jr_addr,
        output i_load_we, i_load_addr, i_load_data,
        input  o_pc, o_pc_next, o_instruction, o_halt, o_state
    );

endinterface

// File: rtl/instr_fetch_mem.sv
// Word-addressed program store: synchronous write, asynchronous read, contents never reset.
module instr_mem #(
    parameter int unsigned NBITS  = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [NBITS-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [NBITS-1:0]  rdata_o
);

    logic [NBITS-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC register, next-PC select, LOAD/RUN/HALTED sequencing and the
// program store feeding the IF/ID register.
module instr_fetch #(
    parameter int unsigned      NBITS     = 32,
    parameter int unsigned      MEM_DEPTH = 64,
    parameter logic [NBITS-1:0] HALT_WORD = instr_fetch_pkg::HALT_WORD
) (
    input logic           i_clk,
    input logic           i_reset,
    instr_fetch_if.slave  bus
);
    import instr_fetch_pkg::*;

    localparam int unsigned      ADDR_W = $clog2(MEM_DEPTH);
    localparam logic [NBITS-1:0] PcStep = NBITS'(4);
    localparam logic [NBITS-1:0] PcMask = ~NBITS'(3);

    state_e           state_q, state_d;
    logic [NBITS-1:0] pc_q, pc_d;
    logic [NBITS-1:0] pc_plus4, target, mem_rdata, instr;
    logic             in_range, halt, mem_we;

    assign pc_plus4 = pc_q + PcStep;
    // Any PC past the last word reads as HALT so running off the program stops the machine.
    assign in_range = (pc_q >> (ADDR_W + 2)) == '0;
    assign mem_we   = bus.i_load_we && (state_q == StLoad);

    instr_mem #(
        .NBITS  (NBITS),
        .DEPTH  (MEM_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (i_clk),
        .we_i    (mem_we),
        .waddr_i (bus.i_load_addr),
        .wdata_i (bus.i_load_data),
        .raddr_i (pc_q[ADDR_W+1:2]),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        instr = NBITS'(NOP_WORD);
        if (state_q != StLoad) begin
            instr = in_range ? mem_rdata : HALT_WORD;
        end
    end

    assign halt = (state_q == StHalted) || ((state_q == StRun) && (instr == HALT_WORD));

    always_comb begin
        target = pc_plus4;
        unique case (bus.i_pc_src)
            PC_SEQ:    target = pc_plus4;
            PC_BRANCH: target = bus.i_branch_addr;
            PC_JUMP:   target = bus.i_jump_addr;
            PC_JR:     target = bus.i_jr_addr;
        endcase
        target = target & PcMask;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            StLoad: begin
                if (bus.i_start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // Priority: enable, then halt, then stall (which also masks redirects).
                if (bus.i_enable) begin
                    if (halt) begin
                        state_d = StHalted;
                    end else if (!bus.i_stall) begin
                        pc_d = target;
                    end
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StLoad;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.o_pc          = pc_q;
    assign bus.o_pc_next     = pc_plus4;
    assign bus.o_instruction = instr;
    assign bus.o_halt        = halt;
    assign bus.o_state       = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: per-scenario row tables, expected observations queued
// as each row is driven and compared one clock later.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int unsigned NBITS     = 32;
    localparam int unsigned MEM_DEPTH = 64;
    localparam int unsigned ADDR_W    = 6;

    localparam logic [31:0] W0 = 32'h2001_0005;
    localparam logic [31:0] W1 = 32'h2002_0007;
    localparam logic [31:0] W2 = 32'h0022_1820;
    localparam logic [31:0] W3 = 32'hFFFF_FFFF;
    localparam logic [31:0] W8 = 32'h8C88_0020;
    localparam logic [31:0] W9 = 32'hAC09_0004;
    localparam logic [31:0] HW = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] instr;
        logic        halt;
    } obs_t;

    typedef struct packed {
        logic        rst;
        logic        start;
        logic        en;
        logic        stall;
        pc_src_e     src;
        logic [31:0] tgt;
        logic        we;
        logic [5:0]  addr;
        logic [31:0] data;
    } stim_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    obs_t  sb[$];
    stim_t rs[$];
    obs_t  re[$];
    obs_t  got, exp;

    always #5 clk = ~clk;

    instr_fetch_if #(.NBITS(NBITS), .ADDR_W(ADDR_W)) bus ();

    instr_fetch #(.NBITS(NBITS), .MEM_DEPTH(MEM_DEPTH)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    function automatic obs_t mk(input state_e s, input logic [31:0] pc, input logic [31:0] ins,
                                input logic h);
        obs_t r;
        r.st      = s;
        r.pc      = pc;
        r.pc_next = pc + 32'd4;
        r.instr   = ins;
        r.halt    = h;
        return r;
    endfunction

    function automatic stim_t stim(input logic en, input logic stall, input pc_src_e src,
                                   input logic [31:0] tgt);
        stim_t s;
        s       = '0;
        s.en    = en;
        s.stall = stall;
        s.src   = src;
        s.tgt   = tgt;
        return s;
    endfunction

    function automatic stim_t idle();
        return stim(1'b1, 1'b0, PC_SEQ, 32'h0);
    endfunction

    function automatic stim_t rst_row();
        stim_t s = idle();
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic stim_t start_row();
        stim_t s = idle();
        s.start = 1'b1;
        return s;
    endfunction

    function automatic stim_t load_row(input logic [5:0] a, input logic [31:0] d,
                                       input logic start);
        stim_t s = idle();
        s.we    = 1'b1;
        s.addr  = a;
        s.data  = d;
        s.start = start;
        return s;
    endfunction

    function automatic obs_t observe();
        obs_t r;
        r.st      = bus.o_state;
        r.pc      = bus.o_pc;
        r.pc_next = bus.o_pc_next;
        r.instr   = bus.o_instruction;
        r.halt    = bus.o_halt;
        return r;
    endfunction

    // Unselected targets get distinct decoys so a wrong mux leg lands on a visible address.
    task automatic apply(input stim_t s);
        rst               = s.rst;
        bus.i_start       = s.start;
        bus.i_enable      = s.en;
        bus.i_stall       = s.stall;
        bus.i_pc_src      = s.src;
        bus.i_branch_addr = (s.src == PC_BRANCH) ? s.tgt : 32'h40;
        bus.i_jump_addr   = (s.src == PC_JUMP)   ? s.tgt : 32'h44;
        bus.i_jr_addr     = (s.src == PC_JR)     ? s.tgt : 32'h48;
        bus.i_load_we     = s.we;
        bus.i_load_addr   = s.addr;
        bus.i_load_data   = s.data;
    endtask

    task automatic add(input stim_t s, input obs_t e);
        rs.push_back(s);
        re.push_back(e);
    endtask

    task automatic test_reset();
        apply(rst_row());
        sb.push_back(mk(StLoad, 32'h0, 32'h0, 1'b0));
        #1;
        got = observe();
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset: got st=%0d pc=%h nx=%h ins=%h halt=%b want st=%0d pc=%h nx=%h ins=%h halt=%b",
                     got.st, got.pc, got.pc_next, got.instr, got.halt,
                     exp.st, exp.pc, exp.pc_next, exp.instr, exp.halt);
        end
        @(negedge clk);
    endtask

    task automatic test_program();
        rs.delete(); re.delete();
        add(load_row(6'd0, W0, 1'b0), mk(StLoad, 32'h0, 32'h0, 1'b0));
        add(load_row(6'd1, W1, 1'b0), mk(StLoad, 32'h0, 32'h0, 1'b0));
        add(load_row(6'd2, W2, 1'b0), mk(StLoad, 32'h0, 32'h0, 1'b0));
        add(load_row(6'd8, W8, 1'b0), mk(StLoad, 32'h0, 32'h0, 1'b0));
        add(load_row(6'd9, W9, 1'b0), mk(StLoad, 32'h0, 32'h0, 1'b0));
        add(load_row(6'd3, W3, 1'b1), mk(StRun, 32'h0, W0, 1'b0));
        add(idle(), mk(StRun, 32'h4, W1, 1'b0));
        add(idle(), mk(StRun, 32'h8, W2, 1'b0));
        add(idle(), mk(StRun, 32'hC, W3, 1'b1));
        add(idle(), mk(StHalted, 32'hC, W3, 1'b1));
        add(start_row(), mk(StHalted, 32'hC, W3, 1'b1));
        for (int i = 0; i < rs.size(); i++) begin
            apply(rs[i]); sb.push_back(re[i]); @(negedge clk);
            got = observe(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL program row %0d: got st=%0d pc=%h nx=%h ins=%h halt=%b want st=%0d pc=%h nx=%h ins=%h halt=%b",
                         i, got.st, got.pc, got.pc_next, got.instr, got.halt,
                         exp.st, exp.pc, exp.pc_next, exp.instr, exp.halt);
            end
        end
    endtask

    task automatic test_stall();
        rs.delete(); re.delete();
        add(rst_row(), mk(StLoad, 32'h0, 32'h0, 1'b0));
        add(start_row(), mk(StRun, 32'h0, W0, 1'b0));
        add(idle(), mk(StRun, 32'h4, W1, 1'b0));
        add(idle(), mk(StRun, 32'h8, W2, 1'b0));
        for (int k = 0; k < 3; k++) add(stim(1'b1, 1'b1, PC_SEQ, 32'h0), mk(StRun, 32'h8, W2, 1'b0));
        add(idle(), mk(StRun, 32'hC, W3, 1'b1));
        for (int i = 0; i < rs.size(); i++) begin
            apply(rs[i]); sb.push_back(re[i]); @(negedge clk);
            got = observe(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL stall row %0d: got st=%0d pc=%h nx=%h ins=%h halt=%b want st=%0d pc=%h nx=%h ins=%h halt=%b",
                         i, got.st, got.pc, got.pc_next, got.instr, got.halt,
                         exp.st, exp.pc, exp.pc_next, exp.instr, exp.halt);
            end
        end
    endtask

    task automatic test_redirect();
        rs.delete(); re.delete();
        add(rst_row(), mk(StLoad, 32'h0, 32'h0, 1'b0));
        add(start_row(), mk(StRun, 32'h0, W0, 1'b0));
        add(idle(), mk(StRun, 32'h4, W1, 1'b0));
        add(stim(1'b1, 1'b1, PC_BRANCH, 32'h22), mk(StRun, 32'h4, W1, 1'b0));
        add(stim(1'b1, 1'b0, PC_BRANCH, 32'h22), mk(StRun, 32'h20, W8, 1'b0));
        add(idle(), mk(StRun, 32'h24, W9, 1'b0));
        add(stim(1'b1, 1'b0, PC_JUMP, 32'h9), mk(StRun, 32'h8, W2, 1'b0));
        add(idle(), mk(StRun, 32'hC, W3, 1'b1));
        add(idle(), mk(StHalted, 32'hC, W3, 1'b1));
        for (int i = 0; i < rs.size(); i++) begin
            apply(rs[i]); sb.push_back(re[i]); @(negedge clk);
            got = observe(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL redirect row %0d: got st=%0d pc=%h nx=%h ins=%h halt=%b want st=%0d pc=%h nx=%h ins=%h halt=%b",
                         i, got.st, got.pc, got.pc_next, got.instr, got.halt,
                         exp.st, exp.pc, exp.pc_next, exp.instr, exp.halt);
            end
        end
    endtask

    task automatic test_jr_out_of_range();
        rs.delete(); re.delete();
        add(rst_row(), mk(StLoad, 32'h0, 32'h0, 1'b0));
        add(start_row(), mk(StRun, 32'h0, W0, 1'b0));
        add(stim(1'b1, 1'b0, PC_JR, 32'h100), mk(StRun, 32'h100, HW, 1'b1));
        add(idle(), mk(StHalted, 32'h100, HW, 1'b1));
        add(stim(1'b1, 1'b0, PC_JR, 32'h4), mk(StHalted, 32'h100, HW, 1'b1));
        add(rst_row(), mk(StLoad, 32'h0, 32'h0, 1'b0));
        add(start_row(), mk(StRun, 32'h0, W0, 1'b0));
        add(stim(1'b1, 1'b0, PC_JR, 32'hFFFF_FFFF), mk(StRun, 32'hFFFF_FFFC, HW, 1'b1));
        add(idle(), mk(StHalted, 32'hFFFF_FFFC, HW, 1'b1));
        for (int i = 0; i < rs.size(); i++) begin
            apply(rs[i]); sb.push_back(re[i]); @(negedge clk);
            got = observe(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL jr row %0d: got st=%0d pc=%h nx=%h ins=%h halt=%b want st=%0d pc=%h nx=%h ins=%h halt=%b",
                         i, got.st, got.pc, got.pc_next, got.instr, got.halt,
                         exp.st, exp.pc, exp.pc_next, exp.instr, exp.halt);
            end
        end
    endtask

    task automatic test_load_in_run();
        rs.delete(); re.delete();
        add(rst_row(), mk(StLoad, 32'h0, 32'h0, 1'b0));
        add(start_row(), mk(StRun, 32'h0, W0, 1'b0));
        add(load_row(6'd0, 32'h1234_5678, 1'b0), mk(StRun, 32'h4, W1, 1'b0));
        add(rst_row(), mk(StLoad, 32'h0, 32'h0, 1'b0));
        add(start_row(), mk(StRun, 32'h0, W0, 1'b0));
        add(idle(), mk(StRun, 32'h4, W1, 1'b0));
        for (int i = 0; i < rs.size(); i++) begin
            apply(rs[i]); sb.push_back(re[i]); @(negedge clk);
            got = observe(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL load_in_run row %0d: got st=%0d pc=%h nx=%h ins=%h halt=%b want st=%0d pc=%h nx=%h ins=%h halt=%b",
                         i, got.st, got.pc, got.pc_next, got.instr, got.halt,
                         exp.st, exp.pc, exp.pc_next, exp.instr, exp.halt);
            end
        end
    endtask

    task automatic test_enable();
        rs.delete(); re.delete();
        add(rst_row(), mk(StLoad, 32'h0, 32'h0, 1'b0));
        add(start_row(), mk(StRun, 32'h0, W0, 1'b0));
        add(idle(), mk(StRun, 32'h4, W1, 1'b0));
        for (int k = 0; k < 5; k++) add(stim(1'b0, 1'b0, PC_JUMP, 32'h20), mk(StRun, 32'h4, W1, 1'b0));
        add(idle(), mk(StRun, 32'h8, W2, 1'b0));
        add(idle(), mk(StRun, 32'hC, W3, 1'b1));
        add(stim(1'b0, 1'b0, PC_SEQ, 32'h0), mk(StRun, 32'hC, W3, 1'b1));
        add(idle(), mk(StHalted, 32'hC, W3, 1'b1));
        for (int i = 0; i < rs.size(); i++) begin
            apply(rs[i]); sb.push_back(re[i]); @(negedge clk);
            got = observe(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL enable row %0d: got st=%0d pc=%h nx=%h ins=%h halt=%b want st=%0d pc=%h nx=%h ins=%h halt=%b",
                         i, got.st, got.pc, got.pc_next, got.instr, got.halt,
                         exp.st, exp.pc, exp.pc_next, exp.instr, exp.halt);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_program();
        test_stall();
        test_redirect();
        test_jr_out_of_range();
        test_load_in_run();
        test_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction-fetch stage and program store. It is the producer side of the IF/ID pipeline register: it drives the next-PC value, the fetched instruction and the halt request into that register, and it consumes the stall and redirect requests from decode/hazard logic. It also holds the word-addressed instruction memory, which the debug unit loads before execution starts.

Parameters:
NBITS, 32, data/instruction/PC width
MEM_DEPTH, 64, instruction memory depth in words (power of 2)
ADDR_W, $clog2(MEM_DEPTH), word-index width (localparam)
HALT_WORD, 32'hFFFF_FFFF, encoding of the HALT instruction

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_enable  in  1  global step/run enable from the debug unit
i_start  in  1  leave LOAD and begin execution
i_stall  in  1  hazard stall; hold PC
i_pc_src  in  2  00 = PC+4, 01 = branch, 10 = jump, 11 = jump-register
i_branch_addr  in  NBITS  branch target (byte address)
i_jump_addr  in  NBITS  jump target (byte address)
i_jr_addr  in  NBITS  register jump target (byte address)
i_load_we  in  1  debug write strobe
i_load_addr  in  ADDR_W  debug word index
i_load_data  in  NBITS  debug write data
o_pc  out  NBITS  current PC (for debug readout)
o_pc_next  out  NBITS  PC+4, goes to IF/ID
o_instruction  out  NBITS  word at the current PC, goes to IF/ID
o_halt  out  1  halt request, goes to the IF/ID halt input
o_state  out  2  FSM state for debug: 0 = LOAD, 1 = RUN, 2 = HALTED

Behaviour:
Reset (asynchronous, active-high):
- State = LOAD, PC = 0.
- Memory contents are not cleared.
- Outputs settle combinationally: o_pc = 0, o_pc_next = 4, o_halt = 0.

LOAD state:
- When i_load_we = 1, write i_load_data to mem[i_load_addr] on the clock edge. Writes are ignored in every other state.
- PC held at 0. o_instruction = 0 (NOP).
- When i_start = 1, go to RUN. If i_load_we and i_start are high in the same cycle, the write completes, then the FSM moves to RUN.

Memory read:
- Asynchronous. o_instruction = mem[PC[ADDR_W+1:2]] in RUN and HALTED.
- If PC >= 4*MEM_DEPTH, o_instruction = HALT_WORD. Running off the end of the program therefore halts the machine.

PC update in RUN, by priority:
1. i_enable = 0: hold.
2. o_halt = 1: hold.
3. i_stall = 1: hold. Stall wins over a simultaneous redirect.
4. Otherwise load the value selected by i_pc_src. Bits [1:0] of any target are forced to 0.
- Arithmetic is modulo 2^NBITS; PC+4 wraps to 0 at 32'hFFFF_FFFC.

Halt:
- o_halt = 1 combinationally when state = RUN and o_instruction == HALT_WORD. The HALT word itself is presented to IF/ID.
- On the next enabled edge the FSM goes to HALTED.
- In HALTED: o_halt = 1, PC frozen, FSM stays until reset.

Fetch latency:
- Instruction for PC is valid in the same cycle. The PC advances on the edge.
- A taken redirect in cycle n makes the target's instruction appear in cycle n+1.

Reset mid-RUN returns to LOAD with the memory contents intact, so the program can be re-run without reloading.

i_start outside LOAD is ignored.

Decomposition:
- Shared package: the i_pc_src encodings (PC_SEQ, PC_BRANCH, PC_JUMP, PC_JR), the state encodings, HALT_WORD and NOP_WORD.
- One natural sub-module: instr_mem (synchronous write, asynchronous read, MEM_DEPTH x NBITS).
- PC register, next-PC mux and FSM live in instr_fetch.

Test Plan:
1. Reset, load mem[0..3] = 0x20010005, 0x20020007, 0x00221820, 0xFFFFFFFF, then pulse i_start.
   Required: o_instruction steps through those four words with o_pc = 0, 4, 8, 12. o_halt rises while o_pc = 12. State = HALTED next cycle, with o_pc still 12 thereafter.
2. In RUN at PC = 8, hold i_stall for 3 cycles.
   Required: o_pc stays 8 and o_instruction stays constant. PC = 12 on the first edge after release.
3. At PC = 4, drive i_pc_src = 01 with i_branch_addr = 0x22.
   Required: next o_pc = 0x20. Repeat with i_stall = 1 at the same time: PC stays at 4.
4. Jump with i_jr_addr = 0x100 and MEM_DEPTH = 64.
   Required: o_instruction = 0xFFFFFFFF, o_halt = 1, then HALTED.
5. Pulse i_load_we in RUN to address 0.
   Required: mem[0] unchanged. Assert reset mid-RUN: state = LOAD, o_pc = 0, earlier program runs again after i_start.
6. In RUN, hold i_enable = 0 for 5 cycles while pulsing i_pc_src = 10.
   Required: PC unchanged. Execution resumes sequentially once i_enable returns high with i_pc_src = 00.
